// File: rtl/cfa_rb_interp_pipe_if.sv
// Sample/result handshake bundle for the CFA R/B chroma interpolation pipe.
// slave = the pipe, master = the window buffer / pixel packer side.
interface cfa_rb_interp_pipe_if #(parameter int DataBitWidth = 12) ();
  logic                    in_valid;
  logic                    in_ready;
  logic [1:0]              in_mode;
  logic [DataBitWidth-1:0] G_c;
  logic [DataBitWidth-1:0] G_n0, G_n1, G_n2, G_n3;
  logic [DataBitWidth-1:0] RB_n0, RB_n1, RB_n2, RB_n3;
  logic                    out_valid;
  logic                    out_ready;
  logic [DataBitWidth-1:0] RB_out;
  logic                    sat;

  modport master (
    output in_valid, in_mode, G_c, G_n0, G_n1, G_n2, G_n3,
           RB_n0, RB_n1, RB_n2, RB_n3, out_ready,
    input  in_ready, out_valid, RB_out, sat
  );

  modport slave (
    input  in_valid, in_mode, G_c, G_n0, G_n1, G_n2, G_n3,
           RB_n0, RB_n1, RB_n2, RB_n3, out_ready,
    output in_ready, out_valid, RB_out, sat
  );
endinterface

// File: rtl/cfa_rb_interp_pipe.sv
// Three-stage R/B interpolation: neighbour sums, colour-difference shift plus
// centre G, then clamp to pixel range. Elastic valid/ready with bubble collapse.

module cfa_rb_tap #(
  parameter int W   = 12,
  parameter int IDX = 0
) (
  input  logic [1:0]   mode,
  input  logic [W-1:0] rb,
  input  logic [W-1:0] g,
  output logic [W-1:0] rb_sel,
  output logic [W-1:0] g_sel
);
  logic en;

  // Taps 0/1 are the horizontal pair, 2/3 the vertical pair; bypass uses none.
  always_comb begin
    en = 1'b0;
    case (mode)
      2'd0:    en = 1'b1;
      2'd1:    en = (IDX < 2);
      2'd2:    en = (IDX >= 2);
      default: en = 1'b0;
    endcase
    rb_sel = en ? rb : '0;
    g_sel  = en ? g  : '0;
  end
endmodule

module cfa_rb_interp_pipe #(
  parameter int DataBitWidth = 12,
  parameter int ROUND        = 0
) (
  input  logic                clk,
  input  logic                rst,
  cfa_rb_interp_pipe_if.slave bus
);
  localparam int W        = DataBitWidth;
  localparam int NUM_TAPS = 4;
  localparam int STAGES   = 3;

  typedef struct packed {
    logic [W+1:0] srb;
    logic [W+1:0] sg;
    logic [1:0]   sh;
    logic [W-1:0] gc;
  } s1_t;

  logic [NUM_TAPS-1:0][W-1:0] rb_n, g_n, rb_sel, g_sel;
  logic [STAGES:1]            vld_pipe;
  logic                       ld1, ld2, ld3;
  s1_t                        s1_d, s1_q;
  logic signed [W+2:0]        d, rnd, q;
  logic signed [W+1:0]        v_d, s2_v;
  logic [W-1:0]               rb_d, rb_r;
  logic                       sat_d, sat_r;

  assign rb_n = {bus.RB_n3, bus.RB_n2, bus.RB_n1, bus.RB_n0};
  assign g_n  = {bus.G_n3, bus.G_n2, bus.G_n1, bus.G_n0};

  for (genvar i = 0; i < NUM_TAPS; i++) begin : g_tap
    cfa_rb_tap #(.W(W), .IDX(i)) u_tap (
      .mode   (bus.in_mode),
      .rb     (rb_n[i]),
      .g      (g_n[i]),
      .rb_sel (rb_sel[i]),
      .g_sel  (g_sel[i])
    );
  end

  // A stage advances when it is empty or its successor advances, so bubbles
  // are squeezed out even while the output is stalled.
  assign ld3          = !vld_pipe[3] || bus.out_ready;
  assign ld2          = !vld_pipe[2] || ld3;
  assign ld1          = !vld_pipe[1] || ld2;
  assign bus.in_ready = ld1;

  // S1: unselected taps arrive as zero, so the sums are just all four taps.
  always_comb begin
    s1_d = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      s1_d.srb = s1_d.srb + {2'b00, rb_sel[i]};
      s1_d.sg  = s1_d.sg  + {2'b00, g_sel[i]};
    end
    case (bus.in_mode)
      2'd0:       s1_d.sh = 2'd2;
      2'd1, 2'd2: s1_d.sh = 2'd1;
      default:    s1_d.sh = 2'd0;
    endcase
    s1_d.gc = bus.G_c;
  end

  // S2: signed difference, optional half-LSB bias, floor shift, add centre G.
  always_comb begin
    rnd = '0;
    if (ROUND != 0) begin
      if (s1_q.sh == 2'd2)      rnd[1] = 1'b1;
      else if (s1_q.sh == 2'd1) rnd[0] = 1'b1;
    end
    d   = $signed({1'b0, s1_q.srb}) - $signed({1'b0, s1_q.sg}) + rnd;
    q   = d >>> s1_q.sh;
    v_d = $signed({2'b00, s1_q.gc}) + $signed(q[W+1:0]);
  end

  // S3: v spans [-(2^W-1), 2^(W+1)-2]; bit W+1 flags negative, bit W overflow.
  always_comb begin
    rb_d  = s2_v[W-1:0];
    sat_d = 1'b0;
    if (s2_v[W+1]) begin
      rb_d  = '0;
      sat_d = 1'b1;
    end else if (s2_v[W]) begin
      rb_d  = '1;
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_v     <= '0;
      rb_r     <= '0;
      sat_r    <= 1'b0;
    end else begin
      if (ld1) vld_pipe[1] <= bus.in_valid;
      if (ld2) vld_pipe[2] <= vld_pipe[1];
      if (ld3) vld_pipe[3] <= vld_pipe[2];
      if (ld1 && bus.in_valid) s1_q <= s1_d;
      if (ld2 && vld_pipe[1])  s2_v <= v_d;
      if (ld3 && vld_pipe[2]) begin
        rb_r  <= rb_d;
        sat_r <= sat_d;
      end
    end
  end

  assign bus.out_valid = vld_pipe[3];
  assign bus.RB_out    = rb_r;
  assign bus.sat       = sat_r;
endmodule

// File: tb/tb_cfa_rb_interp_pipe.sv
// Bench for cfa_rb_interp_pipe: floor and round-half-up instances share one
// stimulus stream; a queue-based reference model tracks every accepted sample.
module tb_cfa_rb_interp_pipe;
  localparam int W    = 12;
  localparam int MAXV = (1 << W) - 1;

  typedef struct packed {
    logic [1:0]          mode;
    logic [W-1:0]        gc;
    logic [3:0][W-1:0]   g;
    logic [3:0][W-1:0]   rb;
    logic [W-1:0]        e0;
    logic                s0;
    logic [W-1:0]        e1;
    logic                s1;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] rb;
    logic         sat;
  } res_t;

  typedef struct packed {
    int           cyc;
    logic [W-1:0] rb0;
    logic         s0;
    logic [W-1:0] rb1;
    logic         s1;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                vin, ordy;
  logic [1:0]          mode;
  logic [W-1:0]        gc;
  logic [3:0][W-1:0]   gn, rbn;

  cfa_rb_interp_pipe_if #(.DataBitWidth(W)) b0 ();
  cfa_rb_interp_pipe_if #(.DataBitWidth(W)) b1 ();

  cfa_rb_interp_pipe #(.DataBitWidth(W), .ROUND(0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  cfa_rb_interp_pipe #(.DataBitWidth(W), .ROUND(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  assign b0.in_valid = vin;    assign b1.in_valid = vin;
  assign b0.in_mode  = mode;   assign b1.in_mode  = mode;
  assign b0.G_c      = gc;     assign b1.G_c      = gc;
  assign b0.G_n0     = gn[0];  assign b1.G_n0     = gn[0];
  assign b0.G_n1     = gn[1];  assign b1.G_n1     = gn[1];
  assign b0.G_n2     = gn[2];  assign b1.G_n2     = gn[2];
  assign b0.G_n3     = gn[3];  assign b1.G_n3     = gn[3];
  assign b0.RB_n0    = rbn[0]; assign b1.RB_n0    = rbn[0];
  assign b0.RB_n1    = rbn[1]; assign b1.RB_n1    = rbn[1];
  assign b0.RB_n2    = rbn[2]; assign b1.RB_n2    = rbn[2];
  assign b0.RB_n3    = rbn[3]; assign b1.RB_n3    = rbn[3];
  assign b0.out_ready = ordy;  assign b1.out_ready = ordy;

  logic [1:0]          ov, ir, st;
  logic [1:0][W-1:0]   rbo;
  assign ov  = {b1.out_valid, b0.out_valid};
  assign ir  = {b1.in_ready, b0.in_ready};
  assign st  = {b1.sat, b0.sat};
  assign rbo = {b1.RB_out, b0.RB_out};

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t q[$];
  vec_t tbl[10];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Straight from the arithmetic rules: select, sum, difference, floor divide, clamp.
  function automatic res_t model(input int md, input int c, input logic [3:0][W-1:0] g,
                                 input logic [3:0][W-1:0] r, input int rnd);
    int srb, sg, s, dd, dv, qq, v;
    res_t res;
    srb = 0; sg = 0; s = 0;
    case (md)
      0: begin
        for (int i = 0; i < 4; i++) begin srb += int'(r[i]); sg += int'(g[i]); end
        s = 2;
      end
      1: begin srb = int'(r[0]) + int'(r[1]); sg = int'(g[0]) + int'(g[1]); s = 1; end
      2: begin srb = int'(r[2]) + int'(r[3]); sg = int'(g[2]) + int'(g[3]); s = 1; end
      default: s = 0;
    endcase
    dd = srb - sg;
    if (rnd != 0 && s > 0) dd += 1 << (s - 1);
    dv = 1 << s;
    qq = (dd >= 0) ? dd / dv : -((-dd + dv - 1) / dv);
    v  = c + qq;
    if (v < 0)         begin res.rb = '0;      res.sat = 1'b1; end
    else if (v > MAXV) begin res.rb = '1;      res.sat = 1'b1; end
    else               begin res.rb = W'(v);   res.sat = 1'b0; end
    return res;
  endfunction

  // Scoreboard: the oldest sample is visible once 3 cycles have passed since it
  // was accepted; room exists while fewer than 3 are held or the output drains.
  always @(negedge clk) begin
    bit   exp_v, exp_ir;
    res_t r0, r1;
    if (!rst) begin
      q.delete();
    end else begin
      exp_v  = (q.size() > 0) && (cyc - q[0].cyc >= 3);
      exp_ir = (q.size() < 3) || ordy;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("out_valid%0d", k), int'(ov[k]), int'(exp_v));
        chk($sformatf("in_ready%0d", k), int'(ir[k]), int'(exp_ir));
      end
      if (exp_v) begin
        chk("rb_out0", int'(rbo[0]), int'(q[0].rb0));
        chk("sat0",    int'(st[0]),  int'(q[0].s0));
        chk("rb_out1", int'(rbo[1]), int'(q[0].rb1));
        chk("sat1",    int'(st[1]),  int'(q[0].s1));
        if (ordy) void'(q.pop_front());
      end
      if (vin && exp_ir) begin
        r0 = model(int'(mode), int'(gc), gn, rbn, 0);
        r1 = model(int'(mode), int'(gc), gn, rbn, 1);
        q.push_back('{cyc: cyc, rb0: r0.rb, s0: r0.sat, rb1: r1.rb, s1: r1.sat});
      end
    end
  end

  function automatic vec_t mk(input int md, input int c, input int g0, input int g1,
                              input int g2, input int g3, input int r0, input int r1,
                              input int r2, input int r3, input int e0, input int s0,
                              input int e1, input int s1);
    vec_t v;
    v.mode = 2'(md);
    v.gc   = W'(c);
    v.g    = {W'(g3), W'(g2), W'(g1), W'(g0)};
    v.rb   = {W'(r3), W'(r2), W'(r1), W'(r0)};
    v.e0   = W'(e0);
    v.s0   = 1'(s0);
    v.e1   = W'(e1);
    v.s1   = 1'(s1);
    return v;
  endfunction

  function automatic int rv();
    return int'($urandom_range(0, MAXV));
  endfunction

  task automatic rand_sample();
    mode = 2'($urandom_range(0, 3));
    gc   = W'($urandom_range(0, MAXV));
    for (int j = 0; j < 4; j++) begin
      gn[j]  = W'($urandom_range(0, MAXV));
      rbn[j] = W'($urandom_range(0, MAXV));
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    @(posedge clk); #1;
    mode = v.mode; gc = v.gc; gn = v.g; rbn = v.rb; vin = 1'b1; ordy = 1'b1;
    @(posedge clk); #1;
    vin = 1'b0;
    lat = 0;
    for (int t = 1; t <= 8 && lat == 0; t++) begin
      @(negedge clk);
      if (ov[0]) lat = t;
    end
    chk($sformatf("vec%0d_latency", idx), lat, 3);
    chk($sformatf("vec%0d_rb_floor", idx), int'(rbo[0]), int'(v.e0));
    chk($sformatf("vec%0d_sat_floor", idx), int'(st[0]), int'(v.s0));
    chk($sformatf("vec%0d_rb_round", idx), int'(rbo[1]), int'(v.e1));
    chk($sformatf("vec%0d_sat_round", idx), int'(st[1]), int'(v.s1));
  endtask

  initial begin
    int acc6, outs, sent;
    vin = 1'b0; ordy = 1'b1; mode = '0; gc = '0; gn = '0; rbn = '0;

    #12;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_out_valid%0d", k), int'(ov[k]), 0);
      chk($sformatf("reset_rb_out%0d", k), int'(rbo[k]), 0);
      chk($sformatf("reset_sat%0d", k), int'(st[k]), 0);
    end
    #1 rst = 1'b1;

    tbl[0] = mk(0, 2000, 1000, 1000, 1000, 1000, 1100, 1100, 1100, 1100, 2100, 0, 2100, 0);
    tbl[1] = mk(0, 4000, 0, 0, 0, 0, 4095, 4095, 4095, 4095, 4095, 1, 4095, 1);
    tbl[2] = mk(0, 10, 1000, 1000, 1000, 1000, 0, 0, 0, 0, 0, 1, 0, 1);
    tbl[3] = mk(1, 100, 1, 1, rv(), rv(), 0, 1, rv(), rv(), 99, 0, 100, 0);
    tbl[4] = mk(2, 100, rv(), rv(), 1, 1, rv(), rv(), 0, 1, 99, 0, 100, 0);
    tbl[5] = mk(3, 1234, rv(), rv(), rv(), rv(), rv(), rv(), rv(), rv(), 1234, 0, 1234, 0);
    tbl[6] = mk(1, 0, 0, 0, rv(), rv(), 4095, 4095, rv(), rv(), 4095, 0, 4095, 0);
    tbl[7] = mk(0, 500, 2, 2, 1, 1, 1, 1, 1, 1, 499, 0, 500, 0);
    tbl[8] = mk(2, 4095, rv(), rv(), 0, 0, rv(), rv(), 1, 1, 4095, 1, 4095, 1);
    tbl[9] = mk(0, 5, 5, 5, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) run_vec(tbl[i], i);

    // Backpressure: six back-to-back offers against a stalled output.
    acc6 = 0; outs = 0; sent = 0;
    for (int c = 0; c < 60 && outs < 6; c++) begin
      @(posedge clk); #1;
      ordy = (c >= 6);
      if (sent < 6) begin vin = 1'b1; rand_sample(); end
      else vin = 1'b0;
      @(negedge clk);
      if (c == 5) chk("bp_in_ready_low", int'(ir[0]), 0);
      if (vin && ir[0]) begin
        sent++;
        if (c < 6) acc6++;
      end
      if (ov[0] && ordy) outs++;
    end
    chk("bp_accepts_while_stalled", acc6, 3);
    chk("bp_outputs_drained", outs, 6);
    @(posedge clk); #1; vin = 1'b0; ordy = 1'b1;
    repeat (5) @(negedge clk);
    chk("bp_queue_empty", q.size(), 0);

    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      vin  = ($urandom_range(0, 3) != 0);
      ordy = 1'($urandom_range(0, 1));
      rand_sample();
    end
    @(posedge clk); #1; vin = 1'b0; ordy = 1'b1;
    repeat (6) @(negedge clk);
    chk("rand_queue_empty", q.size(), 0);

    // Reset mid-stream: two samples in flight, the older one already presented.
    @(posedge clk); #1; vin = 1'b1; ordy = 1'b0; rand_sample(); gc = W'(3000); mode = 2'd3;
    @(posedge clk); #1; rand_sample();
    @(posedge clk); #1; vin = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("midrst_out_valid%0d", k), int'(ov[k]), 0);
      chk($sformatf("midrst_rb_out%0d", k), int'(rbo[k]), 0);
      chk($sformatf("midrst_sat%0d", k), int'(st[k]), 0);
    end
    @(posedge clk); #3;
    rst = 1'b1;
    ordy = 1'b1;
    run_vec(mk(3, 1234, rv(), rv(), rv(), rv(), rv(), rv(), rv(), rv(), 1234, 0, 1234, 0), 10);
    repeat (6) @(negedge clk);
    chk("post_reset_queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cfa_rb_interp_pipe.md
Name: cfa_rb_interp_pipe

Overview:
- Pipelined, parametrised R/B chroma-interpolation kernel for the CFA demosaic datapath.
- Computes a colour-difference estimate from up to four same-colour neighbours (RB) and their co-sited G neighbours, then adds the centre G and clamps to pixel range.
- Supports diagonal 4-tap and axial 2-tap modes, per-sample, with valid/ready flow control.
- Sits between the neighbourhood window buffer and the output pixel packer.

Parameters:
- DataBitWidth, 12, pixel width W (unsigned).
- ROUND, 0, 0 = floor (arithmetic shift); 1 = round-half-up (add 2^(s-1) before shifting by s).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_mode  in  2  0 = diagonal 4-tap, 1 = horizontal 2-tap, 2 = vertical 2-tap, 3 = bypass.
- G_c  in  W  centre green.
- G_n0, G_n1, G_n2, G_n3  in  W each  green at neighbour positions 0..3.
- RB_n0, RB_n1, RB_n2, RB_n3  in  W each  R/B at neighbour positions 0..3.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the output.
- RB_out  out  W  interpolated, clamped R/B value.
- sat  out  1  set if this output was clamped.

Behaviour:
- Reset (rst = 0, async): all stage valid bits, RB_out and sat clear to 0; in_ready = 1 one cycle after deassertion. All in-flight samples are discarded. No partial output after reset.
- Handshake:
  - Transfer on in_valid & in_ready, and on out_valid & out_ready.
  - Payload and out_valid stay stable while out_valid & !out_ready.
- Pipeline: three register stages S1, S2, S3; S3 drives the outputs.
  - Stage k loads when it is empty or stage k+1 loads this cycle (bubbles collapse).
  - S3 loads when it is empty or out_ready = 1.
  - in_ready = S1 loads.
  - Latency is 3 cycles from the input handshake to out_valid with no stall.
  - Throughput is 1 sample/cycle.
  - Capacity is 3 samples: with out_ready held low, the 4th sample is refused.
- S1 (sums), with the mode registered alongside the data:
  - Mode 0: sRB = RB_n0+RB_n1+RB_n2+RB_n3; sG = sum of the four G_n; shift s = 2.
  - Mode 1: sRB = RB_n0+RB_n1; sG = G_n0+G_n1; s = 1.
  - Mode 2: sRB = RB_n2+RB_n3; sG = G_n2+G_n3; s = 1.
  - Mode 3: sums forced to 0; s = 0.
  - Sums are unsigned, W+2 bits. G_c is carried forward.
- S2:
  - d = sRB - sG, signed W+3.
  - If ROUND = 1 and s > 0: d = d + 2^(s-1).
  - q = d >>> s (arithmetic shift, so floor toward -inf).
  - v = G_c + q, signed W+2.
- S3 (clamp):
  - v < 0 gives RB_out = 0, sat = 1.
  - v > 2^W-1 gives RB_out = 2^W-1, sat = 1.
  - Otherwise RB_out = v[W-1:0], sat = 0.
  - Mode 3 therefore outputs G_c with sat = 0.
- No arithmetic overflow is possible at any intermediate width. Unused neighbour ports in modes 1–3 are ignored.
- A simultaneous input and output handshake in the full state is legal and keeps occupancy at 3.
- RB_out and sat hold their last value when out_valid = 0; benches must not check them in that state.

Test Plan:
- Mode 0, W=12, ROUND=0: G_c=2000, G_n*=1000, RB_n*=1100, out_ready=1 → RB_out=2100, sat=0, out_valid exactly 3 cycles after accept.
- High clamp: mode 0, G_c=4000, RB_n*=4095, G_n*=0 → v=8095 → RB_out=4095, sat=1.
- Low clamp: mode 0, G_c=10, RB_n*=0, G_n*=1000 → v=-990 → RB_out=0, sat=1.
- Mode 1 rounding: G_c=100, RB_n0=0, RB_n1=1, G_n0=G_n1=1 (d=-1) → ROUND=0 gives 99; ROUND=1 gives 100. Mode 2 with the same values on indices 2,3 gives the same results, with indices 0,1 randomised.
- Backpressure: stream 6 back-to-back samples with out_ready=0 for 6 cycles, then out_ready=1 →
  - in_ready drops after 3 accepts;
  - the payload is held stable while stalled;
  - all 6 outputs emerge in order with no loss or duplication.
  - Then toggle out_ready randomly and compare against a reference model.
- Reset mid-stream: assert rst=0 asynchronously (between clock edges) with 2 samples in flight → out_valid=0, RB_out=0, sat=0 immediately. After release, a new sample in mode 3 with G_c=1234 → RB_out=1234 after 3 cycles, and no stale outputs appear.
